// File: rtl/sliced_cla_adder.sv
// sliced_cla_adder: multi-cycle adder feeding 4-bit slices through one CLA; optional signed overflow via SLICED_ADDER_OVF_EN
module CarryLookAheadAdder4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] g, p;
  logic c1, c2, c3;
  assign g = a & b;
  assign p = a ^ b;
  assign c1 = g[0] | (p[0] & c_in);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);
  assign s = p ^ {c3, c2, c1, c_in};
endmodule

module sliced_cla_adder #(
  parameter int NUMBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] a_in,
  input  logic [NUMBITS-1:0] b_in,
  input  logic               c_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] s_out,
  output logic               c_out
`ifdef SLICED_ADDER_OVF_EN
  ,
  output logic               ovf_out
`endif
);
  localparam int NSLICE = NUMBITS / 4;
  localparam int CW = $clog2(NSLICE) + 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nxt;
  logic [NUMBITS-1:0] a_reg, b_reg, s_reg, s_nxt;
  logic carry_reg;
  logic [CW-1:0] cnt;
  logic [3:0] cla_s;
  logic cla_c;
  logic last;
  generate
    if ((NUMBITS % 4) != 0 || NUMBITS < 4) begin : g_bad
      $error("sliced_cla_adder: NUMBITS must be a multiple of 4 and >= 4");
    end
    if (NUMBITS == 4) begin : g_s1
      assign s_nxt = cla_s;
    end else begin : g_sn
      assign s_nxt = {cla_s, s_reg[NUMBITS-1:4]};
    end
  endgenerate
  CarryLookAheadAdder4Bit u_cla (
    .a(a_reg[3:0]),
    .b(b_reg[3:0]),
    .c_in(carry_reg),
    .s(cla_s),
    .c_out(cla_c)
  );
  assign last = cnt == CW'(NSLICE - 1);
  assign in_ready = state == IDLE && !reset;
  assign out_valid = state == DONE;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next state: accept in IDLE, leave ADD after the last slice, retire DONE on out_ready
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && in_valid) ? ADD :
                (state == ADD && last) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
  end
  // operand capture, slice shifting and result latching
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      carry_reg <= 1'b0;
      cnt <= '0;
      s_out <= '0;
      c_out <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_reg <= a_in;
      b_reg <= b_in;
      carry_reg <= c_in;
      cnt <= '0;
      s_reg <= '0;
    end else if (state == ADD) begin
      a_reg <= a_reg >> 4;
      b_reg <= b_reg >> 4;
      s_reg <= s_nxt;
      carry_reg <= cla_c;
      cnt <= cnt + CW'(1);
      if (last) begin
        s_out <= s_nxt;
        c_out <= cla_c;
      end
    end
`ifdef SLICED_ADDER_OVF_EN
  logic a_msb, b_msb;
  // operand sign bits kept for the overflow flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_msb <= a_in[NUMBITS-1];
      b_msb <= b_in[NUMBITS-1];
    end
  assign ovf_out = out_valid && (a_msb == b_msb) && (s_reg[NUMBITS-1] != a_msb);
`endif
endmodule

// File: tb/tb_sliced_cla_adder.sv
// tb_sliced_cla_adder: directed checks of the sliced CLA adder plus a NUMBITS=4 exhaustive sweep
module tb_sliced_cla_adder;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 1, c_in = 0;
  logic [15:0] a_in = 0, b_in = 0;
  logic in_ready, out_valid, c_out;
  logic [15:0] s_out;
  logic in_valid4 = 0, c_in4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic in_ready4, out_valid4, c_out4;
  logic [3:0] s4;
  int errors = 0, checks = 0;
`ifdef SLICED_ADDER_OVF_EN
  logic ovf_out, ovf4;
`endif
  always #5 clk = ~clk;

  sliced_cla_adder #(.NUMBITS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .s_out(s_out), .c_out(c_out)
`ifdef SLICED_ADDER_OVF_EN
    , .ovf_out(ovf_out)
`endif
  );

  sliced_cla_adder #(.NUMBITS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .a_in(a4), .b_in(b4), .c_in(c_in4), .out_valid(out_valid4),
    .out_ready(1'b1), .s_out(s4), .c_out(c_out4)
`ifdef SLICED_ADDER_OVF_EN
    , .ovf_out(ovf4)
`endif
  );

  task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         output logic [15:0] s, output logic c, output logic ov,
                         output int lat, output logic ir_ok);
    @(posedge clk); #1;
    a_in = a; b_in = b; c_in = ci; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    ir_ok = 1;
    while (!out_valid && lat < 20) begin
      if (in_ready) ir_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) ir_ok = 0;
    s = s_out;
    c = c_out;
`ifdef SLICED_ADDER_OVF_EN
    ov = ovf_out;
`else
    ov = 0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2 reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, c_out, s_out} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b vld=%b c=%b s=%h want 1 0 0 0000", in_ready, out_valid, c_out, s_out);
    end
  endtask

  task automatic test_basic;
    logic [15:0] s; logic c, ov, ir; int lat;
    run_add(16'h1234, 16'h4321, 0, s, c, ov, lat, ir);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++;
    if (ir !== 1'b1) begin errors++; $display("FAIL basic_in_ready_busy: got in_ready high while busy, want low"); end
    checks++;
    if ({c, s} !== {1'b0, 16'h5555}) begin errors++; $display("FAIL basic_sum: got %b_%h want 0_5555", c, s); end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL basic_retire: got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_wrap;
    logic [15:0] s; logic c, ov, ir; int lat;
    run_add(16'hFFFF, 16'h0001, 0, s, c, ov, lat, ir);
    checks++;
    if ({c, s} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL wrap_sum: got %b_%h want 1_0000", c, s); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL wrap_latency: got %0d want 4", lat); end
  endtask

  task automatic test_backpressure;
    int n;
    @(posedge clk); #1;
    a_in = 16'h00FF; b_in = 16'h0001; c_in = 1; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid && n < 20) begin
      a_in = ~a_in;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", n); end
    for (int i = 0; i < 5; i++) begin
      a_in = ~a_in;
      in_valid = 1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, c_out, s_out} !== {1'b1, 1'b0, 1'b0, 16'h0101}) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b c=%b s=%h want 1 0 0 0101", i, out_valid, in_ready, c_out, s_out);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_retire: got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_no_accept: got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] s; logic c, ov, ir; int lat; logic seen;
    @(posedge clk); #1;
    a_in = 16'hAAAA; b_in = 16'h5555; c_in = 0; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    #1;
    checks++;
    if ({out_valid, in_ready, c_out, s_out} !== {1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL midreset_outputs: got vld=%b rdy=%b c=%b s=%h want 0 0 0 0000", out_valid, in_ready, c_out, s_out);
    end
    @(posedge clk); #1;
    reset = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_valid: got out_valid seen=1 want 0"); end
    run_add(16'h0002, 16'h0003, 0, s, c, ov, lat, ir);
    checks++;
    if ({c, s} !== {1'b0, 16'h0005}) begin errors++; $display("FAIL after_reset_sum: got %b_%h want 0_0005", c, s); end
  endtask

`ifdef SLICED_ADDER_OVF_EN
  task automatic test_ovf;
    logic [15:0] s; logic c, ov, ir; int lat;
    run_add(16'h7FFF, 16'h0001, 0, s, c, ov, lat, ir);
    checks++;
    if ({ov, c, s} !== {1'b1, 1'b0, 16'h8000}) begin errors++; $display("FAIL ovf_pos: got ov=%b c=%b s=%h want 1 0 8000", ov, c, s); end
    run_add(16'h8000, 16'hFFFF, 0, s, c, ov, lat, ir);
    checks++;
    if ({ov, c, s} !== {1'b1, 1'b1, 16'h7FFF}) begin errors++; $display("FAIL ovf_neg: got ov=%b c=%b s=%h want 1 1 7fff", ov, c, s); end
    run_add(16'h7FFF, 16'hFFFF, 0, s, c, ov, lat, ir);
    checks++;
    if ({ov, c, s} !== {1'b0, 1'b1, 16'h7FFE}) begin errors++; $display("FAIL ovf_mixed: got ov=%b c=%b s=%h want 0 1 7ffe", ov, c, s); end
    checks++;
    if (ovf_out !== 1'b0) begin errors++; $display("FAIL ovf_idle: got %b want 0", ovf_out); end
  endtask
`endif

  task automatic test_nbits4_sweep;
    int n;
    logic [4:0] want;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++) begin
          @(posedge clk); #1;
          a4 = 4'(a); b4 = 4'(b); c_in4 = 1'(ci); in_valid4 = 1;
          @(posedge clk); #1;
          in_valid4 = 0;
          n = 0;
          while (!out_valid4 && n < 10) begin
            @(posedge clk); #1;
            n++;
          end
          want = 5'(a + b + ci);
          checks++;
          if (!out_valid4 || {c_out4, s4} !== want) begin
            errors++;
            $display("FAIL sweep4 %0d+%0d+%0d: got vld=%b %b_%h want 1 %b_%h", a, b, ci, out_valid4, c_out4, s4, want[4], want[3:0]);
          end
        end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_reset_mid;
`ifdef SLICED_ADDER_OVF_EN
    test_ovf;
`endif
    test_nbits4_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
